// File: rtl/pagerank_ctrl_pkg.sv
// Shared types and defaults for the PageRank iteration sequencer.
// The FSM state encoding is exported directly on the phase port.
package pagerank_ctrl_pkg;

    localparam int DEF_NUM_HW_THREADS  = 8;
    localparam int DEF_MAX_ITERATIONS  = 100;
    localparam int DEF_WATCHDOG_CYCLES = 65535;
    localparam int WDOG_W              = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STREAM = 3'd2,
        CHECK  = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } ctrl_state_t;

    function automatic logic is_busy(ctrl_state_t s);
        return !(s == IDLE || s == DONE);
    endfunction

endpackage

// File: rtl/pagerank_done_collector.sv
// Sticky per-thread completion flags; all_done includes inputs
// arriving this cycle unless the ignore window is active.
module pagerank_done_collector
    import pagerank_ctrl_pkg::*;
#(
    parameter int N = DEF_NUM_HW_THREADS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         ignore,
    input  logic [N-1:0] done,
    output logic         all_done
);

    logic [N-1:0] flags;
    logic [N-1:0] live;

    assign live     = done & {N{~ignore}};
    assign all_done = &(flags | live);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            flags <= '0;
        end else begin
            flags <= flags | live;
        end
    end

endmodule

// File: rtl/pagerank_iteration_ctrl.sv
// Iteration sequencer for the partitioned PageRank datapath.
// Optional per-phase watchdog: define PAGERANK_WATCHDOG_EN.
module pagerank_iteration_ctrl
    import pagerank_ctrl_pkg::*;
#(
    parameter int NUM_HW_THREADS  = DEF_NUM_HW_THREADS,
    parameter int MAX_ITERATIONS  = DEF_MAX_ITERATIONS,
    parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pagerank_enable,
    input  logic [NUM_HW_THREADS-1:0] scatter_done,
    input  logic [NUM_HW_THREADS-1:0] gather_done,
    input  logic                      stream_done,
    input  logic                      converged_valid,
    input  logic                      converged,
    output logic                      run_start,
    output logic                      stream_start,
    output logic                      nextIteration,
    output logic [31:0]               iteration_number,
    output logic [2:0]                phase,
    output logic                      busy,
    output logic                      pagerank_complete,
    output logic                      timeout_error
);

    ctrl_state_t state;
    ctrl_state_t next_state;

    logic abort;
    logic enter_run;
    logic last_iter;
    logic scatter_all;
    logic gather_all;
    logic flag_clear;
    logic wd_hit;

    assign abort      = !pagerank_enable && is_busy(state);
    assign enter_run  = (next_state == RUN) && (state != RUN);
    assign last_iter  = iteration_number == 32'(MAX_ITERATIONS - 1);
    assign flag_clear = enter_run || abort;
    assign phase      = state;

    // run_start marks the cycle in which stale done levels are ignored
    pagerank_done_collector #(.N(NUM_HW_THREADS)) u_scatter (
        .clock    (clock),
        .reset    (reset),
        .clear    (flag_clear),
        .ignore   (run_start),
        .done     (scatter_done),
        .all_done (scatter_all)
    );

    pagerank_done_collector #(.N(NUM_HW_THREADS)) u_gather (
        .clock    (clock),
        .reset    (reset),
        .clear    (flag_clear),
        .ignore   (run_start),
        .done     (gather_done),
        .all_done (gather_all)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (pagerank_enable) next_state = RUN;
            RUN:     if (scatter_all && gather_all) next_state = STREAM;
            STREAM:  if (stream_done) next_state = CHECK;
            CHECK: begin
                if (converged_valid) begin
                    next_state = (converged || last_iter) ? DONE : NEXT;
                end
            end
            NEXT:    next_state = RUN;
            DONE:    if (!pagerank_enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (wd_hit) next_state = DONE;
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            run_start         <= 1'b0;
            stream_start      <= 1'b0;
            nextIteration     <= 1'b0;
            busy              <= 1'b0;
            pagerank_complete <= 1'b0;
        end else begin
            state             <= next_state;
            run_start         <= enter_run;
            stream_start      <= (next_state == STREAM) && (state != STREAM);
            nextIteration     <= next_state == NEXT;
            busy              <= is_busy(next_state);
            pagerank_complete <= next_state == DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || abort) begin
            iteration_number <= '0;
        end else if (state == IDLE && next_state == RUN) begin
            iteration_number <= '0;
        end else if (state == CHECK && next_state == NEXT) begin
            iteration_number <= iteration_number + 32'd1;
        end
    end

`ifdef PAGERANK_WATCHDOG_EN
    logic [WDOG_W-1:0] wd_cnt;
    logic              wd_active;

    assign wd_active = state inside {RUN, STREAM, CHECK};
    assign wd_hit    = wd_active
                    && (wd_cnt == WDOG_W'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || next_state != state) begin
            wd_cnt <= '0;
        end else if (wd_active) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky until the next run is launched
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_error <= 1'b0;
        end else if (state == IDLE && next_state == RUN) begin
            timeout_error <= 1'b0;
        end else if (wd_hit && !abort) begin
            timeout_error <= 1'b1;
        end
    end
`else
    assign wd_hit        = 1'b0;
    assign timeout_error = 1'b0;
`endif

endmodule

// File: doc/pagerank_iteration_ctrl.md
# pagerank_iteration_ctrl

Iteration sequencer for the partitioned PageRank datapath. Starts the per-partition scatter/local-update threads and collects their completions. It then launches the serial stream into the PageRank compute stage and evaluates convergence. Between iterations it issues the `nextIteration` pulse, and on exit it raises `pagerank_complete`.

## Interface
- `NUM_HW_THREADS`, 8, number of partition threads; must be ≥1.
- `MAX_ITERATIONS`, 100, iteration cap; must be ≥1.
- `WATCHDOG_CYCLES`, 65535, per-phase cycle limit; only used with the watchdog compiled in.

Ports:
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pagerank_enable`  in  1  level.
  - High in IDLE starts a run.
  - Low at any time aborts the run.
- `scatter_done`  in  [NUM_HW_THREADS]  per-thread scatter complete (pulse or level).
- `gather_done`  in  [NUM_HW_THREADS]  per-thread local update complete (pulse or level).
- `stream_done`  in  1  serial stream into compute finished.
- `converged_valid`  in  1  compute stage convergence result valid.
- `converged`  in  1  all deltas below threshold; sampled only with `converged_valid`.
- `run_start`  out  1  one-cycle pulse that starts the threads.
- `stream_start`  out  1  one-cycle pulse that starts serialization.
- `nextIteration`  out  1  one-cycle pulse; the datapath loads `pagerank_final` into `page_rank_init`.
- `iteration_number`  out  32  current iteration, 0-based.
- `phase`  out  3  current FSM state encoding.
- `busy`  out  1  high in every state except IDLE and DONE.
- `pagerank_complete`  out  1  level, high only in DONE.
- `timeout_error`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, RUN, STREAM, CHECK, NEXT, DONE.
- IDLE → RUN: when `pagerank_enable`=1. `iteration_number`←0, and `run_start` is high in the first RUN cycle.
- Done collection in RUN:
  - One sticky flag per thread for scatter and one per thread for gather.
  - All flags are cleared on RUN entry.
  - Inputs are ignored during the `run_start` cycle, which rejects stale levels from the previous iteration.
  - From the next cycle on, any high input sets its flag.
- RUN → STREAM: when every scatter and gather flag is set, including flags set that same cycle. `stream_start` is high in the first STREAM cycle.
- STREAM → CHECK: on `stream_done`.
- CHECK:
  - On `converged_valid`, if `converged`=1 or `iteration_number`==MAX_ITERATIONS-1 → DONE.
  - Otherwise → NEXT.
- NEXT: lasts one cycle. `nextIteration`=1 and `iteration_number` increments. Then → RUN with `run_start`.
- DONE: `pagerank_complete`=1 and `iteration_number` holds. Returns to IDLE when `pagerank_enable`=0.
- Abort: `pagerank_enable`=0 in any busy state → IDLE next cycle.
  - All flags and `iteration_number` clear.
  - No pulses are issued.
- Simultaneous events:
  - Abort has priority over every transition.
  - A watchdog timeout has priority over a normal transition in the same cycle.
- `iteration_number` saturates at MAX_ITERATIONS-1 by construction; it never wraps.

## Timing
- Reset values: state=IDLE, all pulses 0, `iteration_number`=0, `busy`=0, `pagerank_complete`=0, `timeout_error`=0.
- All outputs are registered.
- Enable sampled high at cycle t → `run_start` and `busy` at t+1.
- Last done flag seen at cycle t → `stream_start` at t+1.
- `stream_done` at t → CHECK at t+1.
- `converged_valid` at t (not converged) → `nextIteration` at t+1 → `run_start` at t+2.
- `converged_valid` at t (converged) → `pagerank_complete` at t+1.
- Minimum iteration loop: RUN(2) + STREAM(1) + CHECK(1) + NEXT(1) = 5 cycles.

## Configuration
- `PAGERANK_WATCHDOG_EN` defined:
  - The phase counter clears on every state change and counts in RUN, STREAM and CHECK.
  - On reaching WATCHDOG_CYCLES-1 the FSM goes to DONE with `timeout_error`=1 and `pagerank_complete`=1.
  - `timeout_error` clears only on reset or on the next IDLE→RUN start.
- `PAGERANK_WATCHDOG_EN` not defined: no counter is built and `timeout_error` is tied to 0.

## Structure
- Package `pagerank_ctrl_pkg`:
  - `ctrl_state_t` enum (3-bit, IDLE=0 … DONE=5), which drives `phase`.
  - Default parameter constants.
  - Watchdog counter width constant (32).
- Sub-module `pagerank_done_collector`, instantiated twice (scatter, gather):
  - Inputs: `clear`, `ignore`, `done[NUM_HW_THREADS]`.
  - Output: `all_done`.
  - Holds the sticky flag vector.

## Test plan
- Converge at first check:
  - Stimulus: enable; all 8 gather/scatter dones at staggered cycles 3..10; `stream_done` 4 cycles later; `converged_valid` & `converged`.
  - Response: `pagerank_complete`=1 one cycle later, `iteration_number`=0, exactly one `run_start` and one `stream_start`.
- Iteration cap:
  - Stimulus: MAX_ITERATIONS=3, `converged` always 0.
  - Response: exactly 2 `nextIteration` pulses, then DONE with `iteration_number`=2.
- Stale done rejection:
  - Stimulus: hold all dones high through NEXT and the `run_start` cycle, then drop them.
  - Response: no STREAM until the dones re-assert.
- Last done coincides with one thread pulsing late:
  - Stimulus: thread 7 `gather_done` arrives 1 cycle after the others.
  - Response: `stream_start` exactly 1 cycle after the thread 7 pulse.
- Abort:
  - Stimulus: drop `pagerank_enable` in STREAM.
  - Response: IDLE next cycle, `iteration_number`=0, no `nextIteration` pulse.
- Watchdog (`PAGERANK_WATCHDOG_EN`, WATCHDOG_CYCLES=16):
  - Stimulus: thread 2 never signals done.
  - Response: `timeout_error`=1 and `pagerank_complete`=1 at the 16th RUN cycle.
